// File: rtl/clk_divide_prog.sv
// clk_divide_prog: runtime-programmable integer clock divider (N = 2..2^W-1).
// The ratio is loaded through a shadow register and takes effect only at a
// period boundary, so the output never shows a runt pulse. Also provides a
// per-period tick, a run/pause enable and load ack/error pulses.
// Optional build macro: CLK_DIV_ODD50_EN adds a falling-edge flop that
// stretches the high phase by half a cycle, giving a 50% duty cycle for odd N.
module clk_divide_prog #(
    parameter int unsigned W        = 8,
    parameter int unsigned DIV_INIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] div_val,
    input  logic         div_load,
    output logic         div_ack,
    output logic         div_err,
    output logic         clk_out,
    output logic         tick
);

    localparam logic [W-1:0] INIT_VAL = W'(DIV_INIT);
    localparam logic [W-1:0] ONE      = W'(1);
    localparam logic [W-1:0] TWO      = W'(2);

    // Reject ratios that cannot be represented or cannot toggle
    if ((DIV_INIT < 2) || (DIV_INIT > (2 ** W) - 1)) begin : g_bad_div_init
        $error("clk_divide_prog: DIV_INIT must be in 2..2^W-1");
    end

    logic [W-1:0] r_cnt;
    logic [W-1:0] r_cur;
    logic [W-1:0] r_shadow;
    logic         r_pending;
    logic         r_out;
    logic         r_tick;
    logic         r_ack;
    logic         r_err;

    logic         w_last;
    logic         w_half_last;
    logic         w_bound;
    logic         w_load_ok;
    logic         w_load_bad;

    // Period decode: last count of the period and last count of the high phase
    assign w_last      = (r_cnt == (r_cur - ONE));
    assign w_half_last = (r_cnt == ((r_cur >> 1) - ONE));
    assign w_bound     = en & w_last;
    assign w_load_ok   = div_load & (div_val >= TWO);
    assign w_load_bad  = div_load & (div_val <  TWO);

    // Position counter and registered divided clock; both hold while paused
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (en) begin
            if (w_last) begin
                r_cnt <= '0;
                r_out <= 1'b1;
            end else begin
                r_cnt <= r_cnt + ONE;
            end
            if (w_half_last) begin
                r_out <= 1'b0;
            end
        end
    end

    // Ratio shadowing: a valid load always lands in the shadow (last write
    // wins); a boundary with a pending ratio promotes it to the active ratio.
    // A load in the boundary cycle itself stays pending for the next boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur     <= INIT_VAL;
            r_shadow  <= INIT_VAL;
            r_pending <= 1'b0;
        end else begin
            if (w_bound && r_pending) begin
                r_cur     <= r_shadow;
                r_pending <= 1'b0;
            end
            if (w_load_ok) begin
                r_shadow  <= div_val;
                r_pending <= 1'b1;
            end
        end
    end

    // One-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick <= 1'b0;
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_tick <= w_bound;
            r_ack  <= w_bound & r_pending;
            r_err  <= w_load_bad;
        end
    end

    assign tick    = r_tick;
    assign div_ack = r_ack;
    assign div_err = r_err;

`ifdef CLK_DIV_ODD50_EN
    logic r_out_n;

    // Half-cycle delayed copy of the divided clock
    always_ff @(negedge clk) begin
        if (rst) begin
            r_out_n <= 1'b0;
        end else begin
            r_out_n <= r_out;
        end
    end

    assign clk_out = r_cur[0] ? (r_out | r_out_n) : r_out;
`else
    assign clk_out = r_out;
`endif

endmodule

// File: tb/tb_clk_divide_prog.sv
// Testbench for clk_divide_prog: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a period model.
module tb_clk_divide_prog;

    localparam int unsigned W        = 8;
    localparam int unsigned DIV_INIT = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] div_val;
    logic         div_load;
    logic         div_ack;
    logic         div_err;
    logic         clk_out;
    logic         tick;

    int n_checks = 0;
    int n_fail   = 0;

    clk_divide_prog #(.W(W), .DIV_INIT(DIV_INIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    task automatic chkint(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks where we are in the current period and which ratio is active;
    // the output level is derived from "position < N/2", except during the
    // first period after reset, which is low throughout.
    bit m_valid = 0;
    int m_pos, m_n, m_shadow;
    bit m_pend, m_first;
    bit e_tick, e_ack, e_err, e_r, e_r_prev;

    always @(posedge clk) begin
        bit bnd;
        e_r_prev = e_r;
        if (rst) begin
            m_valid  = 1;
            m_pos    = 0;
            m_n      = DIV_INIT;
            m_shadow = DIV_INIT;
            m_pend   = 0;
            m_first  = 1;
            e_tick   = 0;
            e_ack    = 0;
            e_err    = 0;
        end else if (m_valid) begin
            bnd    = en && (m_pos == m_n - 1);
            e_err  = div_load && (int'(div_val) < 2);
            e_tick = bnd;
            e_ack  = bnd && m_pend;
            if (bnd) begin
                m_pos   = 0;
                m_first = 0;
                if (m_pend) begin
                    m_n    = m_shadow;
                    m_pend = 0;
                end
            end else if (en) begin
                m_pos = m_pos + 1;
            end
            if (div_load && int'(div_val) >= 2) begin
                m_shadow = int'(div_val);
                m_pend   = 1;
            end
        end
        e_r = !m_first && (m_pos < m_n / 2);
        #1;
        if (m_valid) begin
            chk("m_tick", tick, e_tick);
            chk("m_ack", div_ack, e_ack);
            chk("m_err", div_err, e_err);
`ifdef CLK_DIV_ODD50_EN
            chk("m_clk_out", clk_out, (m_n % 2 == 1) ? (e_r | e_r_prev) : e_r);
`else
            chk("m_clk_out", clk_out, e_r);
`endif
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_tick(output int k);
        k = 0;
        do begin
            step();
            k++;
        end while (!tick && k < 300);
        if (k >= 300) chkint("wait_tick_timeout", k, 0);
    endtask

    // Called in a tick cycle; runs to the next tick, counting cycles, high
    // samples and acks (the starting cycle included).
    task automatic measure(output int per, output int hi, output int acks);
        per = 0; hi = 0; acks = 0;
        do begin
            if (clk_out) hi++;
            if (div_ack) acks++;
            per++;
            step();
        end while (!tick && per < 300);
        if (per >= 300) chkint("measure_timeout", per, 0);
    endtask

    initial begin
        int k, per, hi, acks;
        logic held;
        rst = 1'b1; en = 1'b0; div_load = 1'b0; div_val = '0;
        repeat (3) step();
        chk("rst_clk_out", clk_out, 1'b0);
        chk("rst_tick", tick, 1'b0);
        chk("rst_ack", div_ack, 1'b0);

        // A: first period after reset is low for 8 cycles, then 4/4
        rst = 1'b0; en = 1'b1;
        wait_tick(k);
        chkint("first_tick_cycle", k, 8);
        chk("first_rise", clk_out, 1'b1);
        measure(per, hi, acks);
        chkint("p8_period", per, 8);
        chkint("p8_high", hi, 4);

        // B: load 5 mid-period; old period completes, ack with the tick
        step();
        div_load = 1'b1; div_val = 8'd5; step(); div_load = 1'b0;
        wait_tick(k);
        chkint("load5_old_rest", k, 6);
        chk("load5_ack", div_ack, 1'b1);
        measure(per, hi, acks);
        chkint("p5_period", per, 5);
        chkint("p5_high", hi, 2);
        chkint("p5_acks", acks, 1);

        // C: invalid loads 1 and 0
        step();
        div_load = 1'b1; div_val = 8'd1; step();
        chk("err_val1", div_err, 1'b1);
        div_val = 8'd0; step();
        chk("err_val0", div_err, 1'b1);
        div_load = 1'b0; step();
        chk("err_clear", div_err, 1'b0);
        wait_tick(k);
        measure(per, hi, acks);
        chkint("after_err_period", per, 5);
        chkint("after_err_acks", acks, 0);

        // D: load 3 then 6 in one period -> single ack, N=6
        step();
        div_load = 1'b1; div_val = 8'd3; step();
        div_val = 8'd6; step();
        div_load = 1'b0;
        wait_tick(k);
        measure(per, hi, acks);
        chkint("lww_period", per, 6);
        chkint("lww_acks", acks, 1);
        measure(per, hi, acks);
        chkint("lww_period2", per, 6);
        chkint("lww_acks2", acks, 0);

        // E: load 4 exactly in the boundary cycle -> applied one period later
        repeat (5) step();
        div_load = 1'b1; div_val = 8'd4; step(); div_load = 1'b0;
        chk("bnd_tick", tick, 1'b1);
        chk("bnd_no_ack", div_ack, 1'b0);
        measure(per, hi, acks);
        chkint("bnd_old_period", per, 6);
        chkint("bnd_old_acks", acks, 0);
        chk("bnd_late_ack", div_ack, 1'b1);
        measure(per, hi, acks);
        chkint("p4_period", per, 4);
        chkint("p4_high", hi, 2);

        // F: pause 10 cycles at cnt=2, then resume
        repeat (2) step();
        en = 1'b0;
        held = clk_out;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pause_tick", tick, 1'b0);
            chk("pause_clk", clk_out, held);
        end
        en = 1'b1;
        wait_tick(k);
        chkint("resume_ticks", k, 2);

        // G: reset in high phase with a load pending
        div_load = 1'b1; div_val = 8'd7; step(); div_load = 1'b0;
        chk("pre_rst_high", clk_out, 1'b1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid_clk", clk_out, 1'b0);
        acks = 0;
        k = 0;
        do begin
            step();
            k++;
            if (div_ack) acks++;
        end while (!tick && k < 300);
        chkint("rst_first_tick", k, 8);
        chkint("rst_discard_ack", acks, 0);

        // H: randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            en       = ($urandom_range(0, 9) != 0);
            div_load = ($urandom_range(0, 14) == 0);
            div_val  = ($urandom_range(0, 19) == 0) ? W'($urandom_range(0, 40))
                                                     : W'($urandom_range(0, 12));
            step();
        end
        rst = 1'b0; en = 1'b0; div_load = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
